// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains bytes from the UART receive controller's holding
// register into a DEPTH-entry FIFO and exposes a pop interface plus sticky
// error flags to the register slave.
//
// Ports:
//   Clk, Resetn            clock (rising edge), asynchronous active-low reset
//   RX_data, RX_empty      byte and Empty flag from the receive controller
//   RX_overrun             controller Overrun flag (edge-detected into sticky)
//   RX_frame_error         controller Frame_error flag (edge-detected into sticky)
//   Unload_data            one-cycle pulse: controller byte has been taken
//   rd_en                  pop request
//   rd_data, rd_valid      registered popped byte and its one-cycle valid
//   flush                  synchronous FIFO clear
//   clear_status           clears both sticky flags
//   fifo_empty, fifo_full  occupancy status (combinational from level)
//   level                  current occupancy, 0..DEPTH
//   overrun_sticky         latched rising edge of RX_overrun
//   frame_err_sticky       latched rising edge of RX_frame_error
//   rx_irq                 level >= THRESHOLD
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int THRESHOLD  = 1
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic [7:0]            RX_data,
    input  logic                  RX_empty,
    input  logic                  RX_overrun,
    input  logic                  RX_frame_error,
    output logic                  Unload_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  flush,
    input  logic                  clear_status,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overrun_sticky,
    output logic                  frame_err_sticky,
    output logic                  rx_irq
);

    typedef enum logic [1:0] {S_IDLE, S_UNLOAD, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  unload_q, unload_d;
    logic                  ovr_prev_q, ovr_prev_d, fe_prev_q, fe_prev_d;
    logic                  ovr_sticky_q, ovr_sticky_d, fe_sticky_q, fe_sticky_d;
    logic                  push, pop;

    assign fifo_empty       = level_q == '0;
    assign fifo_full        = level_q == (ADDR_WIDTH+1)'(DEPTH);
    assign rx_irq           = level_q >= (ADDR_WIDTH+1)'(THRESHOLD);
    assign level            = level_q;
    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign Unload_data      = unload_q;
    assign overrun_sticky   = ovr_sticky_q;
    assign frame_err_sticky = fe_sticky_q;

    // Push uses pre-pop full and pop uses pre-push level, so a full FIFO
    // delays the push and an empty FIFO ignores the pop in a shared cycle.
    assign push = (state_q == S_IDLE) && !RX_empty && !fifo_full && !flush;
    assign pop  = rd_en && !fifo_empty && !flush;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // S_WAIT holds until the controller raises Empty, so each byte is pushed once.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = push ? S_UNLOAD : S_IDLE;
            S_UNLOAD: state_d = S_WAIT;
            S_WAIT:   state_d = RX_empty ? S_IDLE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unload_d = push;
    end

    always_comb begin
        wr_ptr_d     = flush ? '0 : wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d     = flush ? '0 : rd_ptr_q + ADDR_WIDTH'(pop);
        level_d      = flush ? '0 : level_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        rd_data_d    = pop ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d   = pop;
        ovr_prev_d   = RX_overrun;
        fe_prev_d    = RX_frame_error;
        // A new rising edge wins over a coincident clear.
        ovr_sticky_d = (RX_overrun && !ovr_prev_q) || (ovr_sticky_q && !clear_status);
        fe_sticky_d  = (RX_frame_error && !fe_prev_q) || (fe_sticky_q && !clear_status);
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= RX_data;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            unload_q     <= 1'b0;
            ovr_prev_q   <= 1'b0;
            fe_prev_q    <= 1'b0;
            ovr_sticky_q <= 1'b0;
            fe_sticky_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            unload_q     <= unload_d;
            ovr_prev_q   <= ovr_prev_d;
            fe_prev_q    <= fe_prev_d;
            ovr_sticky_q <= ovr_sticky_d;
            fe_sticky_q  <= fe_sticky_d;
        end
    end

endmodule
